fifo_stream_drain: RTL and testbench
====================================

# fifo_stream_drain

Drains a `basic_sync_fifo`-style read port (shift_out / valid / empty) into a ready/valid output stream with packet framing. It is the stage directly downstream of the synchronous FIFO. It issues FIFO reads only when it has buffer space for the returning word, absorbs the FIFO read latency (0 or 1) in a 2-entry skid buffer, and marks every `PKT_LEN`-th beat with `m_tlast`. Sustained throughput is 1 beat/cycle for either latency.

## Interface
- `DATA_WIDTH`, 32, width of FIFO words and stream data.
- `READ_LATENCY`, 0, FIFO read latency. 0 means `fifo_dout` is valid in the same cycle as `fifo_shift_out`. 1 means it is valid in the next cycle. Other values are illegal.
- `PKT_LEN`, 8, beats per packet. Must be >= 1. Beat counter width is `$clog2(PKT_LEN)`, minimum 1.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  drain enable. When low, no new FIFO reads are issued; data already buffered or in flight is still delivered.
- `fifo_dout`  in  DATA_WIDTH  FIFO read data.
- `fifo_valid`  in  1  FIFO read-data valid.
- `fifo_empty`  in  1  FIFO empty.
- `fifo_shift_out`  out  1  FIFO read request (pop).
- `m_tdata`  out  DATA_WIDTH  stream data.
- `m_tvalid`  out  1  stream valid.
- `m_tready`  in  1  stream ready.
- `m_tlast`  out  1  last beat of packet.
- `pkt_count`  out  16  completed packets; wraps at 2^16.

## Operation
- Storage is a 2-entry in-order buffer (head, tail) with occupancy `occ` in 0..2.
- `inflight` is 1 bit, used only when `READ_LATENCY=1`. It is 1 in the cycle after a read is issued and is tied to 0 when `READ_LATENCY=0`.
- `pop = m_tvalid && m_tready`.
- Read issue is combinational: `fifo_shift_out = rst_n && en && !fifo_empty && (occ + inflight - pop) < 2`.
  - `pop` frees a slot in the same cycle, so steady state sustains 1 read/cycle.
- Capture: when `fifo_valid` is high, `fifo_dout` is written to the buffer on the next edge. It goes behind any existing entries; order is preserved.
  - `fifo_valid` while the buffer is full and not popping cannot occur by construction. The bench asserts this.
  - Simultaneous capture and pop: the head advances, the new word is appended, and `occ` is unchanged.
- Stream side: `m_tvalid = (occ != 0)` and `m_tdata = head`.
  - Once `m_tvalid` is high, `m_tdata` and `m_tlast` are held stable until `pop`.
  - `m_tvalid` never drops without a `pop`.
- Framing: `beat_cnt` increments on each `pop` and wraps to 0 after `PKT_LEN-1`.
  - `m_tlast = m_tvalid && (beat_cnt == PKT_LEN-1)`. With `PKT_LEN=1`, every beat is last.
  - `pkt_count` increments on a `pop` that has `m_tlast=1`.
- Deasserting `en` mid-packet stops new reads only. Framing state is kept, so the packet resumes with the correct beat index when `en` returns.
- FIFO `empty` is consumed as given (including the latency-0 write-bypass case). No read is issued while `fifo_empty` is high.

## Timing
- Reset (while `rst_n` low and on the first cycle after): `m_tvalid=0`, `m_tlast=0`, `fifo_shift_out=0`, `pkt_count=0`, `occ=0`, `inflight=0`, `beat_cnt=0`. `m_tdata` is don't-care.
- Reset mid-operation discards buffered and in-flight words; the upstream FIFO shares `rst_n` and is reset in the same cycle. After reset, any `fifo_valid` is accepted only if a read was issued after reset.
- Latency, empty pipeline, `m_tready` high:
  - `READ_LATENCY=0`: `fifo_shift_out` in cycle N gives `m_tvalid` in cycle N+1.
  - `READ_LATENCY=1`: `fifo_shift_out` in cycle N, `fifo_valid` in N+1, `m_tvalid` in N+2.
- Backpressure: with `m_tready` low, at most 2 words (`occ + inflight <= 2`) are drained from the FIFO, then `fifo_shift_out` stays 0.
- Release: in the cycle `m_tready` rises with `occ=2`, a `pop` occurs and a new read is issued in that same cycle.

## Test plan
- **Streaming, latency 0:** `READ_LATENCY=0`, `PKT_LEN=4`, FIFO preloaded with 0..11, `m_tready=1` -> 12 consecutive beats 0..11 starting at cycle 1; `m_tlast` on beats 3, 7, 11; `pkt_count=3`.
- **Streaming, latency 1:** `READ_LATENCY=1`, same stimulus -> first beat at cycle 2, then 1 beat/cycle with no bubbles; data and `m_tlast` identical to the previous scenario.
- **Backpressure:** `m_tready=0` for 10 cycles with 8 words in the FIFO -> exactly 2 `fifo_shift_out` pulses; `m_tdata=0` held stable; after release, beats 0..7 in order with no loss or duplication.
- **Random ready and enable:** `m_tready` random (50%), `en` toggled randomly, `PKT_LEN=3`, 300 words -> scoreboard order matches; `m_tlast` every 3rd beat; `pkt_count=100`; no read issued while `en=0` or `fifo_empty=1`.
- **Reset mid-packet:** `rst_n` low for 1 cycle after beat 2 of a packet with `occ=2` -> the next cycle shows `m_tvalid=0` and `pkt_count=0`; after refill, `m_tlast` occurs on the `PKT_LEN`-th beat following reset.
- **Single-beat packets:** `PKT_LEN=1`, 5 words -> `m_tlast=1` on every beat; `pkt_count=5`.

Source files
------------

// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain
//   Pulls words out of a synchronous FIFO read port (shift_out / valid / empty)
//   and presents them as a ready/valid stream with packet framing. Reads are
//   only issued when the 2-entry skid buffer can take the returning word, so
//   either FIFO read latency (0 or 1) sustains one beat per cycle.
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   en               drain enable; gates new FIFO reads only
//   fifo_dout        FIFO read data
//   fifo_valid       FIFO read data valid
//   fifo_empty       FIFO empty
//   fifo_shift_out   FIFO pop request (combinational)
//   m_tdata/m_tvalid/m_tready/m_tlast  output stream
//   pkt_count        completed packets, wraps at 2^16
module fifo_stream_drain #(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 0,
    parameter int PKT_LEN      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_valid,
    input  logic                  fifo_empty,
    output logic                  fifo_shift_out,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [15:0]           pkt_count
);

    localparam int            CW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(PKT_LEN - 1);

    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    logic [1:0]            occ;
    logic                  inflight;
    logic [CW-1:0]         beat_cnt;
    logic                  pop;
    logic                  cap;

    assign m_tvalid = (occ != 2'd0);
    assign m_tdata  = head;
    assign m_tlast  = m_tvalid && (beat_cnt == LAST_BEAT);
    assign pop      = m_tvalid && m_tready;

    // A pop in this cycle frees a slot for the word this read returns, which
    // is what keeps back-to-back reads going at full rate.
    assign fifo_shift_out = rst_n && en && !fifo_empty &&
                            (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

    // Only words answering a read issued by this block are captured; a stray
    // valid left over from before a reset is ignored.
    generate
        if (READ_LATENCY == 1) begin : g_lat1
            always_ff @(posedge clk) begin
                if (!rst_n) inflight <= 1'b0;
                else        inflight <= fifo_shift_out;
            end
            assign cap = fifo_valid && inflight;
        end else begin : g_lat0
            assign inflight = 1'b0;
            assign cap      = fifo_valid && fifo_shift_out;
        end
    endgenerate

    // Occupancy and framing state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ       <= 2'd0;
            beat_cnt  <= '0;
            pkt_count <= 16'd0;
        end else begin
            case ({cap, pop})
                2'b10:   if (occ != 2'd2) occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: ;
            endcase
            if (pop) begin
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
                if (m_tlast) pkt_count <= pkt_count + 16'd1;
            end
        end
    end

    // Data slots. head is what the stream shows; tail is the second entry.
    // No reset needed: contents are ignored while occ says they are empty.
    always_ff @(posedge clk) begin
        case ({cap, pop})
            2'b10: begin
                if (occ == 2'd0)      head <= fifo_dout;
                else if (occ == 2'd1) tail <= fifo_dout;
            end
            2'b01: head <= tail;
            2'b11: begin
                // head leaves; the new word goes behind whatever remains
                if (occ == 2'd1) begin
                    head <= fifo_dout;
                end else begin
                    head <= tail;
                    tail <= fifo_dout;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain. Four instances with different read latency and
// packet length share the stimulus; each has its own FIFO model and an
// ordered log of pushed words that serves as the expected stream.
module tb_fifo_stream_drain;
    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;

    function automatic int lat_of(input int g);
        return (g == 1 || g == 2) ? 1 : 0;
    endfunction
    function automatic int pkt_of(input int g);
        return (g < 2) ? 4 : (g == 2) ? 3 : 1;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, en, m_tready;
    logic [DW-1:0] fifo_dout [N];
    logic [DW-1:0] m_tdata [N];
    logic          fifo_valid [N];
    logic          fifo_empty [N];
    logic          fifo_shift_out [N];
    logic          m_tvalid [N];
    logic          m_tlast [N];
    logic [15:0]   pkt_count [N];

    // FIFO model: push log doubles as FIFO storage
    logic [DW-1:0] mem [N][DEPTH];
    logic [9:0]    wr_ptr [N];
    logic [9:0]    rd_ptr [N];
    logic          lat_v [N];
    logic [DW-1:0] lat_d [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        fifo_stream_drain #(
            .DATA_WIDTH  (DW),
            .READ_LATENCY(lat_of(g)),
            .PKT_LEN     (pkt_of(g))
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .en            (en),
            .fifo_dout     (fifo_dout[g]),
            .fifo_valid    (fifo_valid[g]),
            .fifo_empty    (fifo_empty[g]),
            .fifo_shift_out(fifo_shift_out[g]),
            .m_tdata       (m_tdata[g]),
            .m_tvalid      (m_tvalid[g]),
            .m_tready      (m_tready),
            .m_tlast       (m_tlast[g]),
            .pkt_count     (pkt_count[g])
        );
        assign fifo_empty[g] = (rd_ptr[g] == wr_ptr[g]);
        assign fifo_dout[g]  = (lat_of(g) == 1) ? lat_d[g] : mem[g][rd_ptr[g]];
        assign fifo_valid[g] = (lat_of(g) == 1) ? lat_v[g] : fifo_shift_out[g];
    end

    // FIFO shares the reset and is flushed by it
    always @(posedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (!rst_n) begin
                rd_ptr[g] <= wr_ptr[g];
                lat_v[g]  <= 1'b0;
            end else begin
                if (fifo_shift_out[g]) rd_ptr[g] <= rd_ptr[g] + 10'd1;
                lat_v[g] <= fifo_shift_out[g];
                lat_d[g] <= mem[g][rd_ptr[g]];
            end
        end
    end

    // reference model state
    logic [9:0]    exp_ptr [N];
    int            beat [N];
    logic [15:0]   pkt_m [N];
    int            outst [N];
    int            reads [N];
    logic          hold [N];
    logic          hl [N];
    logic          fresh [N];
    logic [DW-1:0] hd [N];
    int            checks, errors;

    task automatic chk(input string tag, input int g, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed %0h expected %0h", tag, g, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input int g, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed %0b expected %0b", tag, g, obs, exp);
        end
    endtask

    // per-cycle scoreboard, run at the falling edge
    task automatic mon();
        for (int g = 0; g < N; g++) begin
            int   p;
            logic pop;
            p   = pkt_of(g);
            pop = m_tvalid[g] && m_tready;
            if (!rst_n) begin
                chkb("rst_rd", g, fifo_shift_out[g], 1'b0);
                exp_ptr[g] = wr_ptr[g];
                beat[g]    = 0;
                pkt_m[g]   = 16'd0;
                outst[g]   = 0;
                hold[g]    = 1'b0;
                fresh[g]   = 1'b1;
                continue;
            end
            if (fresh[g]) begin
                chkb("rst_vld", g, m_tvalid[g], 1'b0);
                chkb("rst_last", g, m_tlast[g], 1'b0);
                fresh[g] = 1'b0;
            end
            if (hold[g]) begin
                chkb("hold_vld", g, m_tvalid[g], 1'b1);
                chk("hold_data", g, m_tdata[g], hd[g]);
                chkb("hold_last", g, m_tlast[g], hl[g]);
            end
            chkb("rd_gate", g, fifo_shift_out[g] && !(en && !fifo_empty[g]), 1'b0);
            chkb("drain_bound", g, (outst[g] + int'(fifo_shift_out[g]) - int'(pop)) <= 2, 1'b1);
            chkb("tlast", g, m_tlast[g], m_tvalid[g] && (beat[g] == p - 1));
            chk("pkt", g, {16'd0, pkt_count[g]}, {16'd0, pkt_m[g]});
            if (pop) begin
                chkb("underflow", g, exp_ptr[g] != wr_ptr[g], 1'b1);
                chk("data", g, m_tdata[g], mem[g][exp_ptr[g]]);
                exp_ptr[g] = exp_ptr[g] + 10'd1;
                if (beat[g] == p - 1) begin
                    beat[g]  = 0;
                    pkt_m[g] = pkt_m[g] + 16'd1;
                end else begin
                    beat[g]++;
                end
            end
            outst[g] = outst[g] + int'(fifo_shift_out[g]) - int'(pop);
            if (fifo_shift_out[g]) reads[g]++;
            hold[g] = m_tvalid[g] && !m_tready;
            hd[g]   = m_tdata[g];
            hl[g]   = m_tlast[g];
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] v);
        for (int g = 0; g < N; g++) begin
            mem[g][wr_ptr[g]] = v;
            wr_ptr[g] = wr_ptr[g] + 10'd1;
        end
    endtask

    function automatic bit drained();
        for (int g = 0; g < N; g++)
            if (exp_ptr[g] != wr_ptr[g]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(input int budget, input string tag);
        for (int i = 0; i < budget && !drained(); i++) tick();
        for (int g = 0; g < N; g++) chkb(tag, g, exp_ptr[g] == wr_ptr[g], 1'b1);
    endtask

    initial begin
        int r0 [N];
        int pushed, cyc;
        checks = 0; errors = 0;
        rst_n = 1'b0; en = 1'b0; m_tready = 1'b0;
        for (int g = 0; g < N; g++) begin
            wr_ptr[g] = 10'd0; exp_ptr[g] = 10'd0; reads[g] = 0;
            beat[g] = 0; pkt_m[g] = 16'd0; outst[g] = 0;
            hold[g] = 1'b0; fresh[g] = 1'b1;
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();                                 // first cycle after reset, FIFO empty

        // streaming: 12 words, always ready; cycle 0 is the push cycle
        en = 1'b1; m_tready = 1'b1;
        for (int i = 0; i < 12; i++) push(DW'(i));
        for (int c = 0; c < 16; c++) begin
            for (int g = 0; g < N; g++)
                chkb("stream_vld", g, m_tvalid[g], (c >= 1 + lat_of(g)) && (c <= 12 + lat_of(g)));
            tick();
        end
        for (int g = 0; g < N; g++) begin
            chkb("stream_done", g, exp_ptr[g] == wr_ptr[g], 1'b1);
            chk("stream_pkt", g, {16'd0, pkt_count[g]}, DW'(12 / pkt_of(g)));
        end

        // backpressure: only two words may leave the FIFO
        m_tready = 1'b0;
        for (int g = 0; g < N; g++) r0[g] = reads[g];
        for (int i = 0; i < 8; i++) push(DW'(i));
        repeat (10) tick();
        for (int g = 0; g < N; g++) begin
            chk("bp_reads", g, DW'(reads[g] - r0[g]), 32'd2);
            chkb("bp_vld", g, m_tvalid[g], 1'b1);
            chk("bp_data", g, m_tdata[g], 32'd0);
        end
        m_tready = 1'b1;
        #1;
        for (int g = 0; g < N; g++) chkb("release_rd", g, fifo_shift_out[g], 1'b1);
        drain(40, "bp_drain");

        // random ready / enable from fresh framing
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        pushed = 0; cyc = 0;
        while ((pushed < 300 || !drained()) && cyc < 6000) begin
            if (pushed < 300 && $urandom_range(0, 9) < 6) begin
                push($urandom);
                pushed++;
            end
            en       = ($urandom_range(0, 3) != 0);
            m_tready = $urandom_range(0, 1) == 1;
            tick();
            cyc++;
        end
        en = 1'b1; m_tready = 1'b1;
        drain(20, "rand_drain");
        for (int g = 0; g < N; g++)
            chk("rand_pkt", g, {16'd0, pkt_count[g]}, DW'(300 / pkt_of(g)));

        // reset two beats into a packet with the buffer full
        for (int i = 0; i < 2; i++) push(DW'(1000 + i));
        drain(10, "pre_rst");
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) push(DW'(2000 + i));
        repeat (4) tick();
        for (int g = 0; g < N; g++) chkb("pre_rst_vld", g, m_tvalid[g], 1'b1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int g = 0; g < N; g++) begin
            chkb("rst_mid_vld", g, m_tvalid[g], 1'b0);
            chk("rst_mid_pkt", g, {16'd0, pkt_count[g]}, 32'd0);
        end
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) push(DW'(3000 + i));
        drain(40, "post_rst");
        for (int g = 0; g < N; g++)
            chk("post_rst_pkt", g, {16'd0, pkt_count[g]}, DW'(8 / pkt_of(g)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
